// File: rtl/m_ext_requester_pkg.sv
// Shared RV32M types: funct3 encoding, M-extension opcode constants and requester FSM states.
package m_ext_requester_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } m_funct3_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_HOLD     = 3'd4
  } m_state_t;

  // funct3[2] splits multiply from divide; within divides bit1 picks remainder, bit0 unsigned.
  function automatic logic is_div_op(input m_funct3_t f);
    return f[2];
  endfunction

  function automatic logic is_quot_op(input m_funct3_t f);
    return !f[1];
  endfunction

  function automatic logic is_signed_div(input m_funct3_t f);
    return f[2] && !f[0];
  endfunction

endpackage

// File: rtl/m_ext_requester_operand_prep.sv
// Combinational operand extension and divide corner-case detection for the M-unit requester.
module m_operand_prep
  import m_ext_requester_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  m_funct3_t       funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN:0]   op_a_c,
  output logic [XLEN:0]   op_b_c,
  output logic            div_signed_c,
  output logic            special_c,
  output logic [XLEN-1:0] special_result_c
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic a_signed;
  logic b_signed;
  logic is_div;
  logic div_by_zero;
  logic overflow;

  always_comb begin
    a_signed         = 1'b0;
    b_signed         = 1'b0;
    is_div           = is_div_op(funct3);
    div_signed_c     = is_signed_div(funct3);
    div_by_zero      = 1'b0;
    overflow         = 1'b0;
    special_c        = 1'b0;
    special_result_c = '0;

    if (is_div) begin
      a_signed    = div_signed_c;
      b_signed    = div_signed_c;
      div_by_zero = (rs2_data == '0);
      overflow    = div_signed_c && (rs1_data == INT_MIN) && (rs2_data == '1);
    end else begin
      a_signed = (funct3 != F3_MULHU);
      b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH);
    end

    op_a_c = {a_signed & rs1_data[XLEN-1], rs1_data};
    op_b_c = {b_signed & rs2_data[XLEN-1], rs2_data};

    // Architectural results for cases resolved without the divider.
    special_c = div_by_zero || overflow;
    if (div_by_zero) begin
      special_result_c = is_quot_op(funct3) ? '1 : rs1_data;
    end else if (overflow) begin
      special_result_c = is_quot_op(funct3) ? INT_MIN : '0;
    end
  end

endmodule

// File: rtl/m_ext_requester.sv
// EX-stage RV32M initiator: issues start pulses to the multiplier/divider, stalls until the
// response, then holds the registered result until the pipeline advances.
module m_ext_requester
  import m_ext_requester_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  m_funct3_t         m_funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              pipe_advance,
  input  logic              m_flush,
  output logic              m_stall,
  output logic [XLEN-1:0]   m_result,
  output logic              mul_enable,
  output logic [XLEN:0]     mul_op_a,
  output logic [XLEN:0]     mul_op_b,
  input  logic              mul_resp,
  input  logic [2*XLEN+1:0] mul_product,
  output logic              div_enable,
  output logic              div_signed,
  input  logic              div_resp,
  input  logic [XLEN-1:0]   div_quotient,
  input  logic [XLEN-1:0]   div_remainder
);

  localparam int unsigned PROD_W = 2 * XLEN + 2;

  m_state_t        state_q;
  m_state_t        state_d;
  m_funct3_t       funct3_q;

  logic [XLEN:0]   op_a_c;
  logic [XLEN:0]   op_b_c;
  logic            prep_div_signed_c;
  logic            special_c;
  logic [XLEN-1:0] special_result_c;

  logic            accept_c;
  logic            load_ops_c;
  logic            load_result_c;
  logic [XLEN-1:0] result_d_c;
  logic            prod_unused_c;

  m_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3           (m_funct3),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .op_a_c           (op_a_c),
    .op_b_c           (op_b_c),
    .div_signed_c     (prep_div_signed_c),
    .special_c        (special_c),
    .special_result_c (special_result_c)
  );

  // Guard bits above the 64-bit product never reach the architectural result.
  assign prod_unused_c = ^mul_product[PROD_W-1:2*XLEN];

  assign accept_c = m_valid && !m_flush && !rst;
  assign m_stall  = m_valid && !m_flush && (state_q != S_HOLD);

  always_comb begin
    state_d       = state_q;
    mul_enable    = 1'b0;
    div_enable    = 1'b0;
    load_ops_c    = 1'b0;
    load_result_c = 1'b0;
    result_d_c    = m_result;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!is_div_op(m_funct3)) begin
            mul_enable = 1'b1;
            load_ops_c = 1'b1;
            state_d    = S_MUL_WAIT;
          end else if (special_c) begin
            load_result_c = 1'b1;
            result_d_c    = special_result_c;
            state_d       = S_HOLD;
          end else begin
            div_enable = 1'b1;
            load_ops_c = 1'b1;
            state_d    = S_DIV_WAIT;
          end
        end
      end

      S_MUL_WAIT: begin
        if (m_flush) begin
          state_d = mul_resp ? S_IDLE : S_DRAIN;
        end else if (mul_resp) begin
          load_result_c = 1'b1;
          result_d_c    = (funct3_q == F3_MUL) ? mul_product[XLEN-1:0]
                                               : mul_product[2*XLEN-1:XLEN];
          state_d       = S_HOLD;
        end
      end

      S_DIV_WAIT: begin
        if (m_flush) begin
          state_d = div_resp ? S_IDLE : S_DRAIN;
        end else if (div_resp) begin
          load_result_c = 1'b1;
          result_d_c    = is_quot_op(funct3_q) ? div_quotient : div_remainder;
          state_d       = S_HOLD;
        end
      end

      // Killed op still owns the back end; swallow its response before accepting new work.
      S_DRAIN: begin
        if (is_div_op(funct3_q) ? div_resp : mul_resp) begin
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (pipe_advance || m_flush) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      funct3_q   <= F3_MUL;
      mul_op_a   <= '0;
      mul_op_b   <= '0;
      div_signed <= 1'b0;
      m_result   <= '0;
    end else begin
      state_q <= state_d;
      if (load_ops_c) begin
        funct3_q   <= m_funct3;
        mul_op_a   <= op_a_c;
        mul_op_b   <= op_b_c;
        div_signed <= prep_div_signed_c;
      end
      if (load_result_c) begin
        m_result <= result_d_c;
      end
    end
  end

endmodule
